// File: rtl/ser_pkg.sv
// Shared serializer definitions: FSM state encoding and bit-counter width helper.
package ser_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    typedef enum logic {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT
    } state_t;

    // Counter must index bits 0..width-1; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: WIDTH-bit words in on valid/ready, one bit per ser_en cycle out.
// First bit appears the cycle after accept; back-to-back words stream with no gap; ser_en=0 freezes the word.
module piso_serializer
    import ser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             ser_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             frame_end
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_sh;
    logic [CW-1:0]    r_cnt;
    logic             r_ser_out;
    logic             r_ser_valid;

    logic             w_last;
    logic             w_in_first;
    logic             w_next_bit;
    logic [WIDTH-1:0] w_sh_shifted;
    logic             w_in_ready;
    logic             w_frame_start;
    logic             w_frame_end;

    assign w_last       = (r_cnt == LAST);
    assign w_in_first   = MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
    assign w_sh_shifted = MSB_FIRST ? {r_sh[WIDTH-2:0], 1'b0} : {1'b0, r_sh[WIDTH-1:1]};
    // ser_out is registered, so it is loaded with the bit that will sit at the output end after the shift.
    assign w_next_bit   = MSB_FIRST ? r_sh[WIDTH-2] : r_sh[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sh        <= '0;
            r_cnt       <= '0;
            r_ser_out   <= IDLE_BIT;
            r_ser_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_sh        <= in_data;
                        r_cnt       <= '0;
                        r_state     <= S_SHIFT;
                        r_ser_out   <= w_in_first;
                        r_ser_valid <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (ser_en) begin
                        if (!w_last) begin
                            r_sh      <= w_sh_shifted;
                            r_cnt     <= r_cnt + CW'(1);
                            r_ser_out <= w_next_bit;
                        end else if (in_valid) begin
                            r_sh      <= in_data;
                            r_cnt     <= '0;
                            r_ser_out <= w_in_first;
                        end else begin
                            r_state     <= S_IDLE;
                            r_ser_valid <= 1'b0;
                            r_ser_out   <= IDLE_BIT;
                        end
                    end
                end
            endcase
        end
    end

    // Ready never looks at in_valid, so no loop through the upstream handshake.
    always_comb begin
        w_in_ready    = ~rst & ((r_state == S_IDLE) | ((r_state == S_SHIFT) & w_last & ser_en));
        w_frame_start = r_ser_valid & (r_cnt == '0);
        w_frame_end   = r_ser_valid & w_last;
    end

    assign in_ready    = w_in_ready;
    assign ser_out     = r_ser_out;
    assign ser_valid   = r_ser_valid;
    assign frame_start = w_frame_start;
    assign frame_end   = w_frame_end;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first/idle-0 and LSB-first/idle-1 instances on shared stimulus.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       ser_en = 1'b0;

    logic rdy_m, out_m, val_m, fs_m, fe_m;
    logic rdy_l, out_l, val_l, fs_l, fe_l;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_m),
        .ser_en(ser_en), .ser_out(out_m), .ser_valid(val_m),
        .frame_start(fs_m), .frame_end(fe_m)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_l),
        .ser_en(ser_en), .ser_out(out_l), .ser_valid(val_l),
        .frame_start(fs_l), .frame_end(fe_l)
    );

    int n_checks = 0;
    int n_err    = 0;
    int rdy_seen = 0;

    // Reference: how many bits of the current word remain to be consumed, and the word itself.
    int         m_left = 0;
    logic [7:0] m_word = 8'h00;
    logic       m_acc  = 1'b0;

    logic cap_m[$];
    logic cap_l[$];
    logic exp_m[$];
    logic exp_l[$];

    task automatic chk(input string tag, input logic act, input logic exp);
        n_checks++;
        assert (act === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, act, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int act, input int exp);
        n_checks++;
        assert (act === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    function automatic int pack_q(input logic q[$]);
        int v = 0;
        foreach (q[i]) v = (v << 1) | int'(q[i]);
        return v;
    endfunction

    task automatic check_outputs();
        logic mv, mr, eb_m, eb_l;
        mv = (m_left > 0);
        mr = !rst && ((m_left == 0) || (m_left == 1 && ser_en));
        eb_m = 1'b0;
        eb_l = 1'b1;
        if (mv) begin
            eb_m = m_word[m_left - 1];
            eb_l = m_word[8 - m_left];
        end
        chk("ready_msb", rdy_m, mr);
        chk("ready_lsb", rdy_l, mr);
        chk("valid_msb", val_m, mv);
        chk("valid_lsb", val_l, mv);
        chk("bit_msb", out_m, eb_m);
        chk("bit_lsb", out_l, eb_l);
        chk("fstart_msb", fs_m, mv && m_left == 8);
        chk("fstart_lsb", fs_l, mv && m_left == 8);
        chk("fend_msb", fe_m, mv && m_left == 1);
        chk("fend_lsb", fe_l, mv && m_left == 1);
    endtask

    task automatic model_update(input logic v, input logic [7:0] d, input logic en);
        m_acc = 1'b0;
        if (rst) begin
            m_left = 0;
        end else begin
            m_acc = v && ((m_left == 0) || (m_left == 1 && en));
            if (m_left > 0 && en) m_left--;
            if (m_acc) begin
                m_word = d;
                m_left = 8;
                for (int k = 0; k < 8; k++) begin
                    exp_m.push_back(d[7 - k]);
                    exp_l.push_back(d[k]);
                end
            end
        end
    endtask

    task automatic cyc(input logic v, input logic [7:0] d, input logic en);
        in_valid = v;
        in_data  = d;
        ser_en   = en;
        @(negedge clk);
        check_outputs();
        if (rdy_m) rdy_seen++;
        if (val_m && en) cap_m.push_back(out_m);
        if (val_l && en) cap_l.push_back(out_l);
        @(posedge clk);
        model_update(v, d, en);
        #1;
    endtask

    task automatic clear_streams();
        cap_m.delete();
        cap_l.delete();
        exp_m.delete();
        exp_l.delete();
    endtask

    task automatic cmp_stream(input string tag);
        chk_int({tag, "_len_msb"}, cap_m.size(), exp_m.size());
        chk_int({tag, "_len_lsb"}, cap_l.size(), exp_l.size());
        for (int i = 0; i < cap_m.size() && i < exp_m.size(); i++)
            chk({tag, "_stream_msb"}, cap_m[i], exp_m[i]);
        for (int i = 0; i < cap_l.size() && i < exp_l.size(); i++)
            chk({tag, "_stream_lsb"}, cap_l[i], exp_l[i]);
        clear_streams();
    endtask

    initial begin
        logic       pend_v;
        logic [7:0] pend_d;
        int         hits;
        int         s;

        // Reset state
        #1 rst = 1'b1;
        #2;
        chk("rst_valid", val_m, 1'b0);
        chk("rst_out_msb", out_m, 1'b0);
        chk("rst_out_lsb", out_l, 1'b1);
        chk("rst_ready", rdy_m, 1'b0);
        chk("rst_fstart", fs_m, 1'b0);
        chk("rst_fend", fe_l, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b1, 8'h33, 1'b1);
        rst = 1'b0;
        cyc(1'b0, 8'h00, 1'b1);
        clear_streams();

        // Single word 0xA5, MSB first
        cyc(1'b1, 8'hA5, 1'b1);
        repeat (9) cyc(1'b0, 8'h00, 1'b1);
        chk_int("t1_bits", cap_m.size(), 8);
        chk_int("t1_word", pack_q(cap_m), 8'hA5);
        cmp_stream("t1");

        // Back-to-back 0xA5, 0x5A held valid
        cyc(1'b1, 8'hA5, 1'b1);
        rdy_seen = 0;
        repeat (8) cyc(1'b1, 8'h5A, 1'b1);
        chk_int("t2_ready_pulses", rdy_seen, 1);
        repeat (9) cyc(1'b0, 8'h00, 1'b1);
        chk_int("t2_stream", pack_q(cap_m), 16'hA55A);
        cmp_stream("t2");

        // Stalled stream, ser_en = 1,0,0,...
        cyc(1'b1, 8'hC3, 1'b1);
        for (int i = 0; i < 24; i++) cyc(1'b1, 8'h77, (i % 3) == 0);
        repeat (10) cyc(1'b0, 8'h00, 1'b1);
        chk_int("t3_word", pack_q(cap_m[0:7]), 8'hC3);
        cmp_stream("t3");

        // LSB-first instance on 0x0A -> 0,1,0,1,0,0,0,0
        cyc(1'b1, 8'h0A, 1'b1);
        repeat (9) cyc(1'b0, 8'h00, 1'b1);
        chk_int("t4_lsb_bits", pack_q(cap_l), 8'h50);
        cmp_stream("t4");

        // Asynchronous reset mid-word
        cyc(1'b1, 8'hFF, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_async_valid_msb", val_m, 1'b0);
        chk("t5_async_valid_lsb", val_l, 1'b0);
        chk("t5_async_out_msb", out_m, 1'b0);
        chk("t5_async_out_lsb", out_l, 1'b1);
        chk("t5_async_ready", rdy_m, 1'b0);
        m_left = 0;
        clear_streams();
        @(posedge clk);
        #1;
        cyc(1'b1, 8'h3C, 1'b1);
        rst = 1'b0;
        repeat (3) cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b1, 8'h81, 1'b1);
        repeat (9) cyc(1'b0, 8'h00, 1'b1);
        chk_int("t5_after_reset", pack_q(cap_m), 8'h81);
        cmp_stream("t5");

        // 0xAA, 0xAA: 1010 must appear across the word boundary with no gap
        cyc(1'b1, 8'hAA, 1'b1);
        repeat (8) cyc(1'b1, 8'hAA, 1'b1);
        repeat (9) cyc(1'b0, 8'h00, 1'b1);
        s = pack_q(cap_m);
        hits = 0;
        for (int i = 0; i + 4 <= 16; i++)
            if (((s >> (12 - i)) & 4'hF) == 4'hA) hits++;
        chk_int("t6_stream", s, 16'hAAAA);
        chk_int("t6_1010_hits", hits, 7);
        cmp_stream("t6");

        // Randomised traffic against the reference
        pend_v = 1'b0;
        pend_d = 8'h00;
        for (int c = 0; c < 600; c++) begin
            if (!pend_v && $urandom_range(0, 3) != 0) begin
                pend_v = 1'b1;
                pend_d = 8'($urandom);
            end
            cyc(pend_v, pend_d, $urandom_range(0, 3) != 0);
            if (m_acc) pend_v = 1'b0;
        end
        repeat (40) cyc(1'b0, 8'h00, 1'b1);
        cmp_stream("rand");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
